// File: rtl/cnn_pkg.sv
// Shared types and constants for the CNN block engines.
// Holds the pooling FSM state encoding and the output-dimension helper.
package cnn_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      READ  = 3'd1,
      DRAIN = 3'd2,
      EMIT  = 3'd3,
      FLUSH = 3'd4,
      DONE  = 3'd5
   } pool_state_t;

   // Valid (unpadded) pooling output size along one axis.
   function automatic int OUT_DIM(input int in, input int pool, input int stride);
      return (in - pool) / stride + 1;
   endfunction

endpackage

// File: rtl/pool_accumulator.sv
// Per-window max / sum accumulator with average division on the output side.
// The first element of a window seeds the accumulator in both modes.
module pool_accumulator
   import cnn_pkg::*;
#(
   parameter int BIT_WIDTH = 16,
   parameter int POOL_SIZE = 3
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        en,
   input  logic                        first,
   input  logic                        avg,
   input  logic signed [BIT_WIDTH-1:0] din,
   output logic signed [BIT_WIDTH-1:0] result
);

   localparam int ACC_W = BIT_WIDTH + $clog2(POOL_SIZE * POOL_SIZE);
   localparam logic signed [ACC_W-1:0] DIV = ACC_W'(POOL_SIZE * POOL_SIZE);

   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] din_ext;
   logic signed [ACC_W-1:0] quo;

   assign din_ext = din;
   // Signed division truncates toward zero, which is the required rounding.
   assign quo     = acc / DIV;
   assign result  = avg ? quo[BIT_WIDTH-1:0] : acc[BIT_WIDTH-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
      end else if (en) begin
         if (first)
            acc <= din_ext;
         else if (avg)
            acc <= acc + din_ext;
         else if (din_ext > acc)
            acc <= din_ext;
      end
   end

endmodule

// File: rtl/pool2d_engine.sv
// 2-D max/average pooling engine: walks every window of a CHW feature map in
// word-packed RAM, reduces it, and packs results into output RAM words.
module pool2d_engine
   import cnn_pkg::*;
#(
   parameter int INPUT_X              = 128,
   parameter int INPUT_Y              = 128,
   parameter int CHANNELS             = 4,
   parameter int POOL_SIZE            = 3,
   parameter int STRIDE               = 3,
   parameter int BIT_WIDTH            = 16,
   parameter int RAM_WIDTH_MULTIPLIER = 2,
   localparam int M         = RAM_WIDTH_MULTIPLIER,
   localparam int OX        = OUT_DIM(INPUT_X, POOL_SIZE, STRIDE),
   localparam int OY        = OUT_DIM(INPUT_Y, POOL_SIZE, STRIDE),
   localparam int IN_WORDS  = (CHANNELS * INPUT_X * INPUT_Y + M - 1) / M,
   localparam int OUT_WORDS = (CHANNELS * OX * OY + M - 1) / M,
   localparam int AW_RD     = (IN_WORDS > 1) ? $clog2(IN_WORDS) : 1,
   localparam int AW_WR     = (OUT_WORDS > 1) ? $clog2(OUT_WORDS) : 1,
   localparam int DW        = BIT_WIDTH * M
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             avg_mode,
   output logic             rd_en,
   output logic [AW_RD-1:0] addr_rd,
   input  logic [DW-1:0]    data_rd,
   output logic             wren,
   output logic [AW_WR-1:0] addr_wr,
   output logic [DW-1:0]    data_wr,
   output logic             busy,
   output logic             done
);

   localparam int LW = (M > 1) ? $clog2(M) : 1;

   pool_state_t state, nxt;
   int kx, ky, ox, oy, ch, cnt, idx;
   logic avg_q, rd_q, first_q, last_rd, last_win;
   logic [LW-1:0] lane_q;
   logic [M-1:0][BIT_WIDTH-1:0] rd_lanes, pack, pack_nxt;
   logic signed [BIT_WIDTH-1:0] din, result;

   assign last_rd  = (kx == POOL_SIZE - 1) && (ky == POOL_SIZE - 1);
   assign last_win = (ox == OX - 1) && (oy == OY - 1) && (ch == CHANNELS - 1);

   always_comb begin
      nxt = state;
      case (state)
         IDLE:    if (start) nxt = READ;
         READ:    if (last_rd) nxt = DRAIN;
         DRAIN:   nxt = EMIT;
         EMIT:    nxt = last_win ? FLUSH : READ;
         FLUSH:   nxt = DONE;
         DONE:    nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   assign idx     = ch * INPUT_X * INPUT_Y + (oy * STRIDE + ky) * INPUT_X + ox * STRIDE + kx;
   assign rd_en   = (state == READ);
   assign addr_rd = rd_en ? AW_RD'(idx / M) : '0;
   assign busy    = state inside {READ, DRAIN, EMIT, FLUSH};
   assign done    = (state == DONE);

   assign rd_lanes = data_rd;
   assign din      = rd_lanes[lane_q];

   always_comb begin
      pack_nxt = pack;
      pack_nxt[LW'(cnt)] = result;
   end

   pool_accumulator #(.BIT_WIDTH(BIT_WIDTH), .POOL_SIZE(POOL_SIZE)) u_acc (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (rd_q),
      .first  (first_q),
      .avg    (avg_q),
      .din    (din),
      .result (result)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         kx      <= 0;
         ky      <= 0;
         ox      <= 0;
         oy      <= 0;
         ch      <= 0;
         cnt     <= 0;
         avg_q   <= 1'b0;
         rd_q    <= 1'b0;
         first_q <= 1'b0;
         lane_q  <= '0;
         pack    <= '0;
         wren    <= 1'b0;
         addr_wr <= '0;
         data_wr <= '0;
      end else begin
         state   <= nxt;
         rd_q    <= rd_en;
         first_q <= rd_en && (kx == 0) && (ky == 0);
         lane_q  <= LW'(idx % M);
         wren    <= 1'b0;
         // Address advances on the cycle after each write pulse.
         if (wren) addr_wr <= addr_wr + AW_WR'(1);
         case (state)
            IDLE: if (start) begin
               avg_q   <= avg_mode;
               addr_wr <= '0;
            end
            READ: begin
               if (kx == POOL_SIZE - 1) begin
                  kx <= 0;
                  ky <= (ky == POOL_SIZE - 1) ? 0 : ky + 1;
               end else begin
                  kx <= kx + 1;
               end
            end
            EMIT: begin
               if (cnt == M - 1) begin
                  wren    <= 1'b1;
                  data_wr <= pack_nxt;
                  pack    <= '0;
                  cnt     <= 0;
               end else begin
                  pack <= pack_nxt;
                  cnt  <= cnt + 1;
               end
               if (last_win) begin
                  ox <= 0;
                  oy <= 0;
                  ch <= 0;
               end else if (ox == OX - 1) begin
                  ox <= 0;
                  if (oy == OY - 1) begin
                     oy <= 0;
                     ch <= ch + 1;
                  end else begin
                     oy <= oy + 1;
                  end
               end else begin
                  ox <= ox + 1;
               end
            end
            FLUSH: if (cnt != 0) begin
               wren    <= 1'b1;
               data_wr <= pack;
               pack    <= '0;
               cnt     <= 0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_pool2d_engine.sv
// Directed bench for pool2d_engine: three parameterisations driven from small
// RAM models, with writes and done pulses logged and compared to hand values.
module tb_pool2d_engine;

   logic clk, rst_n, avg_mode;
   logic start_a, start_b, start_c;

   // A: 4x4x1 P2 S2   B: 5x5x1 P3 S2   C: 3x3x3 P3 S3   (all M=2, 16-bit)
   logic        rd_en_a, rd_en_b, rd_en_c;
   logic [2:0]  addr_rd_a;
   logic [3:0]  addr_rd_b, addr_rd_c;
   logic [31:0] data_rd_a, data_rd_b, data_rd_c;
   logic        wren_a, wren_b, wren_c;
   logic [0:0]  addr_wr_a, addr_wr_b, addr_wr_c;
   logic [31:0] data_wr_a, data_wr_b, data_wr_c;
   logic        busy_a, busy_b, busy_c, done_a, done_b, done_c;

   logic [31:0] mem_a [8];
   logic [31:0] mem_b [13];
   logic [31:0] mem_c [14];

   int          log_addr [3][64];
   logic [31:0] log_data [3][64];
   int          nw [3];
   int          nd [3];
   int errors = 0;
   int checks = 0;

   pool2d_engine #(.INPUT_X(4), .INPUT_Y(4), .CHANNELS(1), .POOL_SIZE(2), .STRIDE(2),
                   .BIT_WIDTH(16), .RAM_WIDTH_MULTIPLIER(2)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .avg_mode(avg_mode),
      .rd_en(rd_en_a), .addr_rd(addr_rd_a), .data_rd(data_rd_a),
      .wren(wren_a), .addr_wr(addr_wr_a), .data_wr(data_wr_a),
      .busy(busy_a), .done(done_a));

   pool2d_engine #(.INPUT_X(5), .INPUT_Y(5), .CHANNELS(1), .POOL_SIZE(3), .STRIDE(2),
                   .BIT_WIDTH(16), .RAM_WIDTH_MULTIPLIER(2)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .avg_mode(avg_mode),
      .rd_en(rd_en_b), .addr_rd(addr_rd_b), .data_rd(data_rd_b),
      .wren(wren_b), .addr_wr(addr_wr_b), .data_wr(data_wr_b),
      .busy(busy_b), .done(done_b));

   pool2d_engine #(.INPUT_X(3), .INPUT_Y(3), .CHANNELS(3), .POOL_SIZE(3), .STRIDE(3),
                   .BIT_WIDTH(16), .RAM_WIDTH_MULTIPLIER(2)) dut_c (
      .clk(clk), .rst_n(rst_n), .start(start_c), .avg_mode(avg_mode),
      .rd_en(rd_en_c), .addr_rd(addr_rd_c), .data_rd(data_rd_c),
      .wren(wren_c), .addr_wr(addr_wr_c), .data_wr(data_wr_c),
      .busy(busy_c), .done(done_c));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM models (one-cycle read latency) and write / done logging.
   always @(posedge clk) begin
      if (rd_en_a) data_rd_a <= mem_a[addr_rd_a];
      if (rd_en_b) data_rd_b <= mem_b[addr_rd_b];
      if (rd_en_c) data_rd_c <= mem_c[addr_rd_c];
      if (wren_a) begin log_addr[0][nw[0]] = int'(addr_wr_a); log_data[0][nw[0]] = data_wr_a; nw[0]++; end
      if (wren_b) begin log_addr[1][nw[1]] = int'(addr_wr_b); log_data[1][nw[1]] = data_wr_b; nw[1]++; end
      if (wren_c) begin log_addr[2][nw[2]] = int'(addr_wr_c); log_data[2][nw[2]] = data_wr_c; nw[2]++; end
      if (done_a) nd[0]++;
      if (done_b) nd[1]++;
      if (done_c) nd[2]++;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Pulse start on one instance, optionally re-pulse it at cycle `poke`,
   // and wait (bounded) for done while counting busy cycles.
   task automatic run(input int which, input logic avg, input int poke, output int busy_cyc);
      logic d, b;
      bit seen = 0;
      @(negedge clk);
      avg_mode = avg;
      case (which) 0: start_a = 1'b1; 1: start_b = 1'b1; default: start_c = 1'b1; endcase
      @(negedge clk);
      start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
      busy_cyc = 0;
      for (int i = 0; i < 500; i++) begin
         d = (which == 0) ? done_a : (which == 1) ? done_b : done_c;
         b = (which == 0) ? busy_a : (which == 1) ? busy_b : busy_c;
         if (d) begin seen = 1; break; end
         if (b) busy_cyc++;
         start_a = (which == 0 && i == poke);
         @(negedge clk);
         start_a = 1'b0;
      end
      if (!seen) chk("done_timeout", 0, 1);
      @(negedge clk);
   endtask

   int base, dbase, bc;

   initial begin
      rst_n = 1'b0; avg_mode = 1'b0;
      start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
      data_rd_a = '0; data_rd_b = '0; data_rd_c = '0;
      for (int w = 0; w < 8; w++) mem_a[w] = {16'(2 * w + 1), 16'(2 * w)};
      for (int w = 0; w < 13; w++) mem_b[w] = 32'hFFFD_FFFD;
      for (int w = 0; w < 14; w++) mem_c[w] = '0;
      for (int e = 0; e < 27; e++) mem_c[e / 2][(e % 2) * 16 +: 16] = 16'(e / 9 + 1);

      repeat (3) @(negedge clk);
      chk("reset_rd_en", rd_en_a, 0);
      chk("reset_busy_done", {busy_a, done_a, wren_a}, 0);
      chk("reset_addrs", {addr_rd_a, addr_wr_a}, 0);
      chk("reset_data_wr", data_wr_a, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // A max: windows 5,7,13,15
      base = nw[0]; dbase = nd[0];
      run(0, 1'b0, -1, bc);
      chk("a_max_busy_cycles", bc, 25);
      chk("a_max_wcount", nw[0] - base, 2);
      chk("a_max_w0", {log_addr[0][base], log_data[0][base]}, {32'd0, 32'h0007_0005});
      chk("a_max_w1", {log_addr[0][base+1], log_data[0][base+1]}, {32'd1, 32'h000F_000D});
      chk("a_max_done", nd[0] - dbase, 1);

      // A avg: 2,4,10,12
      base = nw[0];
      run(0, 1'b1, -1, bc);
      chk("a_avg_wcount", nw[0] - base, 2);
      chk("a_avg_w0", log_data[0][base], 32'h0004_0002);
      chk("a_avg_w1", log_data[0][base+1], 32'h000C_000A);

      // B avg of all -3, exact multiple of M: no flush write
      base = nw[1];
      run(1, 1'b1, -1, bc);
      chk("b_busy_cycles", bc, 45);
      chk("b_wcount", nw[1] - base, 2);
      chk("b_w0", {log_addr[1][base], log_data[1][base]}, {32'd0, 32'hFFFD_FFFD});
      chk("b_w1", {log_addr[1][base+1], log_data[1][base+1]}, {32'd1, 32'hFFFD_FFFD});

      // C max per channel, odd result count -> partial flush word
      base = nw[2];
      run(2, 1'b0, -1, bc);
      chk("c_busy_cycles", bc, 34);
      chk("c_wcount", nw[2] - base, 2);
      chk("c_w0", {log_addr[2][base], log_data[2][base]}, {32'd0, 32'h0002_0001});
      chk("c_flush", {log_addr[2][base+1], log_data[2][base+1]}, {32'd1, 32'h0000_0003});

      // Reset in the middle of a READ phase, then a clean rerun.
      base = nw[0];
      @(negedge clk);
      avg_mode = 1'b0; start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      repeat (2) @(negedge clk);
      chk("mid_read_active", rd_en_a, 1);
      rst_n = 1'b0;
      #1;
      chk("rst_rd_en_busy", {rd_en_a, busy_a, done_a, wren_a}, 0);
      chk("rst_addrs", {addr_rd_a, addr_wr_a}, 0);
      chk("rst_data_wr", data_wr_a, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("no_resume", {busy_a, rd_en_a}, 0);
      chk("no_partial_writes", nw[0] - base, 0);
      run(0, 1'b0, -1, bc);
      chk("rerun_w0", {log_addr[0][base], log_data[0][base]}, {32'd0, 32'h0007_0005});
      chk("rerun_w1", {log_addr[0][base+1], log_data[0][base+1]}, {32'd1, 32'h000F_000D});

      // Second start while busy must be ignored.
      base = nw[0]; dbase = nd[0];
      run(0, 1'b0, 5, bc);
      repeat (30) @(negedge clk);
      chk("busy_start_done", nd[0] - dbase, 1);
      chk("busy_start_wcount", nw[0] - base, 2);
      chk("busy_start_idle", busy_a, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
